// File: rtl/alu_op_sequencer.sv
// Issue-side controller for the register-file / ALU / writeback-mux datapath.
// Accepts one instruction per handshake and sequences RF reads, ALU and writeback.
module alu_op_sequencer #(
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        instr_is_load,
    input  logic [3:0]  instr_op,
    input  logic [4:0]  instr_rs1,
    input  logic [4:0]  instr_rs2,
    input  logic [4:0]  instr_rd,
    input  logic [3:0]  instr_shamt,
    input  logic        instr_sign,
    input  logic [31:0] instr_imm,
    input  logic [31:0] alu_result,
    output logic [4:0]  rr1,
    output logic [4:0]  rr2,
    output logic [4:0]  wr,
    output logic        we,
    output logic [3:0]  op,
    output logic [3:0]  shamount,
    output logic        sign,
    output logic        mux_ctrl,
    output logic [31:0] write_data,
    output logic        done,
    output logic [31:0] done_result,
    output logic        err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_REJ  = 3'd4;

    localparam logic [5:0] NREG = 6'(NUM_REGS);

    logic [2:0]  state_q, state_d;
    logic [4:0]  rr1_q, rr1_d;
    logic [4:0]  rr2_q, rr2_d;
    logic [4:0]  wr_q, wr_d;
    logic        we_q, we_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  shamount_q, shamount_d;
    logic        sign_q, sign_d;
    logic        mux_ctrl_q, mux_ctrl_d;
    logic [31:0] write_data_q, write_data_d;
    logic        done_q, done_d;
    logic [31:0] done_result_q, done_result_d;
    logic        err_q, err_d;

    logic accept;
    logic bad_rd;
    logic bad_rs;
    logic bad_idx;

    assign instr_ready = (state_q == S_IDLE);
    assign accept      = instr_valid & instr_ready;

    // Out-of-range index detection; sources only matter for ALU instructions.
    always_comb begin
        bad_rd  = ({1'b0, instr_rd} >= NREG);
        bad_rs  = ({1'b0, instr_rs1} >= NREG) | ({1'b0, instr_rs2} >= NREG);
        bad_idx = bad_rd | (~instr_is_load & bad_rs);
    end

    // Next-state and registered-output computation for the issue sequence.
    always_comb begin
        state_d       = state_q;
        rr1_d         = rr1_q;
        rr2_d         = rr2_q;
        wr_d          = wr_q;
        we_d          = we_q;
        op_d          = op_q;
        shamount_d    = shamount_q;
        sign_d        = sign_q;
        mux_ctrl_d    = mux_ctrl_q;
        write_data_d  = write_data_q;
        done_d        = 1'b0;
        done_result_d = done_result_q;
        err_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad_idx) begin
                        state_d = S_REJ;
                        we_d    = 1'b0;
                    end else if (instr_is_load) begin
                        state_d      = S_LOAD;
                        wr_d         = instr_rd;
                        write_data_d = instr_imm;
                        mux_ctrl_d   = 1'b0;
                        we_d         = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        rr1_d      = instr_rs1;
                        rr2_d      = instr_rs2;
                        op_d       = instr_op;
                        shamount_d = instr_shamt;
                        sign_d     = instr_sign;
                        wr_d       = instr_rd;
                        we_d       = 1'b0;
                    end
                end
            end
            S_READ: begin
                state_d    = S_EXEC;
                mux_ctrl_d = 1'b1;
                we_d       = 1'b1;
            end
            S_EXEC: begin
                state_d       = S_IDLE;
                we_d          = 1'b0;
                done_d        = 1'b1;
                done_result_d = alu_result;
            end
            S_LOAD: begin
                state_d       = S_IDLE;
                we_d          = 1'b0;
                done_d        = 1'b1;
                done_result_d = write_data_q;
            end
            S_REJ: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr1_q         <= '0;
            rr2_q         <= '0;
            wr_q          <= '0;
            we_q          <= 1'b0;
            op_q          <= '0;
            shamount_q    <= '0;
            sign_q        <= 1'b0;
            mux_ctrl_q    <= 1'b0;
            write_data_q  <= '0;
            done_q        <= 1'b0;
            done_result_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr1_q         <= rr1_d;
            rr2_q         <= rr2_d;
            wr_q          <= wr_d;
            we_q          <= we_d;
            op_q          <= op_d;
            shamount_q    <= shamount_d;
            sign_q        <= sign_d;
            mux_ctrl_q    <= mux_ctrl_d;
            write_data_q  <= write_data_d;
            done_q        <= done_d;
            done_result_q <= done_result_d;
            err_q         <= err_d;
        end
    end

    assign rr1         = rr1_q;
    assign rr2         = rr2_q;
    assign wr          = wr_q;
    assign we          = we_q;
    assign op          = op_q;
    assign shamount    = shamount_q;
    assign sign        = sign_q;
    assign mux_ctrl    = mux_ctrl_q;
    assign write_data  = write_data_q;
    assign done        = done_q;
    assign done_result = done_result_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: RF/ALU environment plus an
// architectural register model that predicts every retirement.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_is_load;
    logic [3:0]  instr_op;
    logic [4:0]  instr_rs1, instr_rs2, instr_rd;
    logic [3:0]  instr_shamt;
    logic        instr_sign;
    logic [31:0] instr_imm;
    logic [31:0] alu_result;
    logic [4:0]  rr1, rr2, wr;
    logic        we;
    logic [3:0]  op, shamount;
    logic        sign, mux_ctrl;
    logic [31:0] write_data;
    logic        done;
    logic [31:0] done_result;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;

    logic [31:0] rf [0:7];
    logic [31:0] rd1, rd2;
    logic [31:0] regs_m [0:7];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_op_sequencer #(.NUM_REGS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_is_load(instr_is_load), .instr_op(instr_op),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
        .instr_shamt(instr_shamt), .instr_sign(instr_sign),
        .instr_imm(instr_imm), .alu_result(alu_result),
        .rr1(rr1), .rr2(rr2), .wr(wr), .we(we),
        .op(op), .shamount(shamount), .sign(sign),
        .mux_ctrl(mux_ctrl), .write_data(write_data),
        .done(done), .done_result(done_result), .err(err)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0] s,
                                          input logic g);
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << s;
            4'd6: return $unsigned($signed(a) >>> s);
            4'd7: return g ? {31'b0, $signed(a) > $signed(b)} : {31'b0, a > b};
            4'd8: return g ? {31'b0, $signed(a) < $signed(b)} : {31'b0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result = alu_f(op, rd1, rd2, shamount, sign);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (we && wr < 5'd8)
            rf[wr[2:0]] <= mux_ctrl ? alu_result : write_data;
        rd1 <= (rr1 < 5'd8) ? rf[rr1[2:0]] : 32'h0;
        rd2 <= (rr2 < 5'd8) ? rf[rr2[2:0]] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        instr_is_load = 1'($urandom);
        instr_op      = 4'($urandom);
        instr_rs1     = 5'($urandom);
        instr_rs2     = 5'($urandom);
        instr_rd      = 5'($urandom);
        instr_shamt   = 4'($urandom);
        instr_sign    = 1'($urandom);
        instr_imm     = $urandom;
    endtask

    // Called at a negedge with the sequencer idle; returns at the
    // negedge right after retirement (valid left high if hold).
    task automatic issue(input bit ld, input logic [3:0] o,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic [3:0] sh,
                         input logic g, input logic [31:0] imm,
                         input bit hold);
        bit bad;
        logic [31:0] exp;
        bad = (d >= 5'd8) || (!ld && (s1 >= 5'd8 || s2 >= 5'd8));
        instr_valid   = 1'b1;
        instr_is_load = ld;
        instr_op      = o;
        instr_rs1     = s1;
        instr_rs2     = s2;
        instr_rd      = d;
        instr_shamt   = sh;
        instr_sign    = g;
        instr_imm     = imm;
        check("ready_before", {31'b0, instr_ready}, 32'd1);
        @(negedge clk);
        acc_cyc = cyc;
        scramble();
        if (!hold) instr_valid = 1'b0;
        check("busy_ready", {31'b0, instr_ready}, 32'd0);
        check("busy_done", {31'b0, done}, 32'd0);
        if (bad) begin
            check("rej_we0", {31'b0, we}, 32'd0);
            @(negedge clk);
            check("rej_done", {31'b0, done}, 32'd1);
            check("rej_err", {31'b0, err}, 32'd1);
            check("rej_we1", {31'b0, we}, 32'd0);
            check("rej_res", done_result, last_res);
        end else if (ld) begin
            check("ld_we", {31'b0, we}, 32'd1);
            check("ld_wr", {27'b0, wr}, {27'b0, d});
            check("ld_mux", {31'b0, mux_ctrl}, 32'd0);
            check("ld_wdata", write_data, imm);
            @(negedge clk);
            regs_m[d[2:0]] = imm;
            last_res = imm;
            check("ld_we_off", {31'b0, we}, 32'd0);
            check("ld_done", {31'b0, done}, 32'd1);
            check("ld_err", {31'b0, err}, 32'd0);
            check("ld_res", done_result, last_res);
        end else begin
            exp = alu_f(o, regs_m[s1[2:0]], regs_m[s2[2:0]], sh, g);
            check("rd_we", {31'b0, we}, 32'd0);
            check("rd_rr1", {27'b0, rr1}, {27'b0, s1});
            check("rd_rr2", {27'b0, rr2}, {27'b0, s2});
            check("rd_op", {28'b0, op}, {28'b0, o});
            check("rd_sh", {28'b0, shamount}, {28'b0, sh});
            check("rd_sign", {31'b0, sign}, {31'b0, g});
            @(negedge clk);
            check("ex_we", {31'b0, we}, 32'd1);
            check("ex_wr", {27'b0, wr}, {27'b0, d});
            check("ex_mux", {31'b0, mux_ctrl}, 32'd1);
            check("ex_done", {31'b0, done}, 32'd0);
            check("ex_ready", {31'b0, instr_ready}, 32'd0);
            @(negedge clk);
            regs_m[d[2:0]] = exp;
            last_res = exp;
            check("alu_we_off", {31'b0, we}, 32'd0);
            check("alu_done", {31'b0, done}, 32'd1);
            check("alu_err", {31'b0, err}, 32'd0);
            check("alu_res", done_result, last_res);
        end
        check("ready_after", {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        int a0, a1, a2;
        bit ld, hold;
        logic [4:0] d, s1, s2;
        for (int i = 0; i < 8; i++) begin
            rf[i]     = 32'h0;
            regs_m[i] = 32'h0;
        end
        last_res    = 32'h0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_outs", {rr1, rr2, wr, we, op, shamount, sign, mux_ctrl, done, err},
              32'h0);
        check("rst_wdata", write_data, 32'h0);
        check("rst_res", done_result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // loads, add, shift and compare
        issue(1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFCB, 0);
        check("t1_r1", done_result, 32'hFFFFFFCB);
        issue(1, 0, 0, 0, 2, 0, 0, 32'h00000003, 0);
        check("t1_r2", done_result, 32'h00000003);
        issue(0, 4'd0, 1, 2, 3, 0, 0, 32'h0, 0);
        check("t2_add", done_result, 32'hFFFFFFCE);
        issue(1, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFB, 0);
        issue(0, 4'd6, 1, 0, 4, 4'd2, 0, 32'h0, 0);
        check("t3_sra", done_result, 32'hFFFFFFFE);
        issue(0, 4'd7, 1, 2, 5, 0, 1, 32'h0, 0);
        check("t3_cmp", done_result, 32'h0);

        // back-to-back ALU ops with valid held high
        issue(0, 4'd1, 3, 1, 6, 0, 0, 32'h0, 1);
        a0 = acc_cyc;
        issue(0, 4'd4, 6, 2, 7, 0, 0, 32'h0, 1);
        a1 = acc_cyc;
        issue(0, 4'd8, 1, 2, 0, 0, 1, 32'h0, 1);
        a2 = acc_cyc;
        instr_valid = 1'b0;
        check("t4_gap1", a1 - a0, 32'd3);
        check("t4_gap2", a2 - a1, 32'd3);
        check("t4_last", done_result, 32'd1);

        // rejected destination
        issue(0, 4'd0, 1, 2, 9, 0, 0, 32'h0, 0);

        // idle with valid low must not accept
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", {31'b0, instr_ready}, 32'd1);
            check("idle_done", {31'b0, done}, 32'd0);
        end

        // reset during READ: nothing written, no done
        instr_valid = 1'b1; instr_is_load = 1'b0; instr_op = 4'd0;
        instr_rs1 = 5'd1; instr_rs2 = 5'd2; instr_rd = 5'd3;
        @(negedge clk);
        instr_valid = 1'b0;
        check("r6_read", {31'b0, instr_ready}, 32'd0);
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("r6_we", {31'b0, we}, 32'd0);
            check("r6_done", {31'b0, done}, 32'd0);
        end
        rst_n = 1'b1;
        last_res = 32'h0;
        @(negedge clk);
        check("r6_ready", {31'b0, instr_ready}, 32'd1);
        issue(1, 0, 0, 0, 2, 0, 0, 32'h12345678, 0);

        // reset during LOAD: write still lands, no done
        instr_valid = 1'b1; instr_is_load = 1'b1;
        instr_rd = 5'd6; instr_imm = 32'hCAFEF00D;
        @(negedge clk);
        instr_valid = 1'b0;
        check("rl_we", {31'b0, we}, 32'd1);
        rst_n = 1'b0;
        regs_m[6] = 32'hCAFEF00D;
        @(negedge clk);
        check("rl_we0", {31'b0, we}, 32'd0);
        check("rl_done", {31'b0, done}, 32'd0);
        check("rl_res", done_result, 32'h0);
        rst_n = 1'b1;
        last_res = 32'h0;
        @(negedge clk);
        issue(0, 4'd0, 6, 0, 7, 0, 0, 32'h0, 0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            ld   = ($urandom_range(0, 2) == 0);
            d    = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(8, 31))
                                                : 5'($urandom_range(0, 7));
            s1   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(8, 31))
                                                : 5'($urandom_range(0, 7));
            s2   = 5'($urandom_range(0, 7));
            hold = 1'($urandom);
            issue(ld, 4'($urandom_range(0, 8)), s1, s2, d,
                  4'($urandom), 1'($urandom), $urandom, hold);
            if (!hold) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("gap_done", {31'b0, done}, 32'd0);
                end
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            check($sformatf("rf%0d", i), rf[i], regs_m[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
